// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bus writes land in a circular FIFO and are
// serialised LSB first on tx, with a per-frame latched baud prescaler.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic [15:0]                   prescale,
  input  logic [7:0]                    wdata,
  input  logic                          wr,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          tx_done,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push, drop, pop;

  logic [15:0]  psc_q, psc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   idx_q, idx_d;
  logic         stop_q, stop_d;
  logic         tx_q, tx_d;
  logic         done_q, done_d;
  logic         ovf_q;
  logic         tick;

  // Write port: wr is a one-cycle request with no back-pressure. It is taken
  // when full (registered) is low at that edge; otherwise the byte is dropped
  // and the sticky ovf flag records the loss.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign push  = wr & ~full;
  assign drop  = wr & full;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr[AW-1:0]];
          psc_d   = prescale;
          cnt_d   = prescale;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = psc_q;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = psc_q;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = psc_q;
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx comes straight off a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/randomised bench for uart_tx_fifo; frames are checked cycle by cycle
// against bit patterns built from the byte, the prescale and the stop count.
module tb_uart_tx_fifo;

  // clock / reset
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // instance with one stop bit
  logic        en, wr, ovf_clr;
  logic [15:0] prescale;
  logic [7:0]  wdata;
  logic        tx, busy, full, empty, ovf, tx_done;
  logic [4:0]  level;
  logic [1:0]  state_dbg;

  // instance with two stop bits
  logic        en2, wr2, ovf_clr2;
  logic [15:0] prescale2;
  logic [7:0]  wdata2;
  logic        tx2, busy2, full2, empty2, ovf2, tx_done2;
  logic [4:0]  level2;
  logic [1:0]  state_dbg2;

  uart_tx_fifo #(.FIFO_DEPTH(16), .STOP_BITS(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale),
    .wdata(wdata), .wr(wr), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
    .full(full), .empty(empty), .level(level), .ovf(ovf),
    .tx_done(tx_done), .state_dbg(state_dbg)
  );

  uart_tx_fifo #(.FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en2), .prescale(prescale2),
    .wdata(wdata2), .wr(wr2), .ovf_clr(ovf_clr2), .tx(tx2), .busy(busy2),
    .full(full2), .empty(empty2), .level(level2), .ovf(ovf2),
    .tx_done(tx_done2), .state_dbg(state_dbg2)
  );

  int sel = 0;
  logic obs_tx, obs_done;
  assign obs_tx   = (sel == 0) ? tx : tx2;
  assign obs_done = (sel == 0) ? tx_done : tx_done2;

  // scoreboard
  int checks = 0;
  int failures = 0;
  int last_done = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_byte(input int s, input logic [7:0] b);
    @(posedge HCLK); #1;
    if (s == 0) begin wr = 1'b1; wdata = b; end
    else begin wr2 = 1'b1; wdata2 = b; end
    @(posedge HCLK); #1;
    wr = 1'b0;
    wr2 = 1'b0;
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    @(negedge HCLK);
    while (obs_tx !== 1'b0 && n < 400) begin
      @(negedge HCLK);
      n++;
    end
    chk(32'(n < 400), 32'd1, {tag, " start timeout"});
  endtask

  // Entered at the sample point of the first start-bit cycle; returns at the
  // sample point where tx_done must be high. act 1 drops en, act 2 moves prescale2.
  task automatic check_frame(input logic [7:0] b, input int psc, input int sb,
                             input int act_cycle, input int act, input string tag);
    int c;
    logic e, got, done_early;
    logic [7:0] dec;
    c = 0;
    dec = 8'h00;
    done_early = 1'b0;
    for (int bi = 0; bi < 9 + sb; bi++) begin
      if (bi == 0) e = 1'b0;
      else if (bi <= 8) e = b[bi-1];
      else e = 1'b1;
      got = e;
      for (int k = 0; k <= psc; k++) begin
        if (c == act_cycle) begin
          if (act == 1) en = 1'b0;
          else if (act == 2) prescale2 = 16'd7;
        end
        if (obs_tx !== e && got === e) got = obs_tx;
        if (obs_done !== 1'b0) done_early = 1'b1;
        if (bi >= 1 && bi <= 8 && k == psc / 2) dec[bi-1] = obs_tx;
        @(negedge HCLK);
        c++;
      end
      chk(32'(got), 32'(e), $sformatf("%s bit%0d", tag, bi));
    end
    chk(32'(done_early), 32'd0, {tag, " tx_done early"});
    chk(32'(obs_done), 32'd1, {tag, " tx_done"});
    chk(32'(obs_tx), 32'd1, {tag, " idle after stop"});
    chk(32'(dec), 32'(b), {tag, " decoded byte"});
    last_done = cyc;
  endtask

  task automatic next_exp(output logic [7:0] b, input string tag);
    chk(32'(exp_q.size() > 0), 32'd1, {tag, " expected queue"});
    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int t0, n, p, done_cnt;
    logic bad;

    en = 0; wr = 0; ovf_clr = 0; wdata = 0; prescale = 16'd15;
    en2 = 0; wr2 = 0; ovf_clr2 = 0; wdata2 = 0; prescale2 = 16'd0;

    // 1: reset values, then 0x55 at prescale 15
    repeat (3) @(negedge HCLK);
    chk(32'(tx), 1, "rst tx");
    chk(32'(busy), 0, "rst busy");
    chk(32'(full), 0, "rst full");
    chk(32'(empty), 1, "rst empty");
    chk(32'(level), 0, "rst level");
    chk(32'(ovf), 0, "rst ovf");
    chk(32'(tx_done), 0, "rst tx_done");
    chk(32'(tx2), 1, "rst tx2");
    HRESETn = 1'b1;
    en = 1'b1;
    push_byte(0, 8'h55);
    @(negedge HCLK);
    chk(32'(tx), 1, "t1 tx at edge k");
    chk(32'(level), 1, "t1 level at edge k");
    chk(32'(empty), 0, "t1 empty at edge k");
    @(negedge HCLK);
    chk(32'(tx), 0, "t1 tx at edge k+1");
    chk(32'(busy), 1, "t1 busy");
    chk(32'(level), 0, "t1 level after pop");
    check_frame(8'h55, 15, 1, -1, 0, "t1");
    @(negedge HCLK);
    chk(32'(tx_done), 0, "t1 tx_done one cycle");
    chk(32'(busy), 0, "t1 busy after");

    // 2: overflow with en low, then drain
    en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_byte(0, 8'(i));
      if (i < 16) exp_q.push_back(8'(i));
      @(negedge HCLK);
      chk(32'(level), (i < 16) ? i + 1 : 16, $sformatf("t2 level w%0d", i));
      chk(32'(full), 32'(i >= 15), $sformatf("t2 full w%0d", i));
      chk(32'(ovf), 32'(i == 16), $sformatf("t2 ovf w%0d", i));
    end
    @(posedge HCLK); #1;
    wr = 1'b1; wdata = 8'hEE; ovf_clr = 1'b1;
    @(posedge HCLK); #1;
    wr = 1'b0; ovf_clr = 1'b0;
    @(negedge HCLK);
    chk(32'(ovf), 1, "t2 ovf set wins");
    chk(32'(level), 16, "t2 level after drop");
    @(posedge HCLK); #1;
    en = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      if (j == 0) wait_fall("t2");
      else begin
        @(negedge HCLK);
        chk(32'(tx), 0, $sformatf("t2 gap %0d", j));
      end
      next_exp(b, "t2");
      check_frame(b, 15, 1, -1, 0, $sformatf("t2 f%0d", j));
      done_cnt++;
    end
    @(negedge HCLK);
    chk(32'(done_cnt), 16, "t2 frames");
    chk(32'(empty), 1, "t2 empty");
    chk(32'(busy), 0, "t2 busy");
    chk(32'(ovf), 1, "t2 ovf sticky");
    @(posedge HCLK); #1; ovf_clr = 1'b1;
    @(posedge HCLK); #1; ovf_clr = 1'b0;
    @(negedge HCLK);
    chk(32'(ovf), 0, "t2 ovf cleared");

    // 3: streaming at prescale 3
    en = 1'b0;
    prescale = 16'd3;
    push_byte(0, 8'hA3); exp_q.push_back(8'hA3);
    push_byte(0, 8'h0F); exp_q.push_back(8'h0F);
    @(posedge HCLK); #1; en = 1'b1;
    wait_fall("t3");
    next_exp(b, "t3");
    check_frame(b, 3, 1, -1, 0, "t3 f0");
    t0 = last_done;
    @(negedge HCLK);
    chk(32'(tx), 0, "t3 gap");
    next_exp(b, "t3");
    check_frame(b, 3, 1, -1, 0, "t3 f1");
    chk(32'(last_done - t0), 41, "t3 tx_done spacing");

    // random streams
    for (int r = 0; r < 3; r++) begin
      @(negedge HCLK);
      en = 1'b0;
      p = $urandom_range(0, 4);
      n = $urandom_range(3, 6);
      prescale = 16'(p);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push_byte(0, b);
        exp_q.push_back(b);
      end
      @(posedge HCLK); #1; en = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (i == 0) wait_fall("rnd");
        else begin
          @(negedge HCLK);
          chk(32'(tx), 0, $sformatf("rnd%0d gap %0d", r, i));
        end
        t0 = last_done;
        next_exp(b, "rnd");
        check_frame(b, p, 1, -1, 0, $sformatf("rnd%0d f%0d", r, i));
        if (i > 0) chk(32'(last_done - t0), 10 * (p + 1) + 1, $sformatf("rnd%0d spacing %0d", r, i));
      end
    end

    // 4: en dropped mid-data
    @(negedge HCLK);
    en = 1'b0;
    prescale = 16'd3;
    push_byte(0, 8'h81); exp_q.push_back(8'h81);
    push_byte(0, 8'h3C); exp_q.push_back(8'h3C);
    @(posedge HCLK); #1; en = 1'b1;
    wait_fall("t4");
    next_exp(b, "t4");
    check_frame(b, 3, 1, 12, 1, "t4 f0");
    bad = 1'b0;
    repeat (30) begin
      @(negedge HCLK);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk(32'(bad), 0, "t4 quiet while en low");
    chk(32'(level), 1, "t4 level held");
    @(posedge HCLK); #1; en = 1'b1;
    wait_fall("t4 resume");
    next_exp(b, "t4");
    check_frame(b, 3, 1, -1, 0, "t4 f1");

    // 5: asynchronous reset during data bit 4
    @(negedge HCLK);
    en = 1'b0;
    push_byte(0, 8'h00);
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    @(posedge HCLK); #1; en = 1'b1;
    wait_fall("t5");
    repeat (21) @(negedge HCLK);
    chk(32'(tx), 0, "t5 tx before reset");
    chk(32'(level), 2, "t5 level before reset");
    #1 HRESETn = 1'b0;
    #1;
    chk(32'(tx), 1, "t5 tx async");
    chk(32'(level), 0, "t5 level async");
    chk(32'(busy), 0, "t5 busy async");
    @(negedge HCLK);
    HRESETn = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge HCLK);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk(32'(bad), 0, "t5 no activity after reset");
    chk(32'(empty), 1, "t5 empty");

    // 6: two stop bits, prescale 0, prescale moved mid-frame
    sel = 1;
    push_byte(1, 8'hFF);
    @(posedge HCLK); #1; en2 = 1'b1;
    wait_fall("t6");
    t0 = cyc;
    check_frame(8'hFF, 0, 2, 3, 2, "t6 f0");
    chk(32'(last_done - t0), 11, "t6 tx_done after fall");
    push_byte(1, 8'h5A);
    wait_fall("t6 next");
    check_frame(8'h5A, 7, 2, -1, 0, "t6 f1");
    sel = 0;

    chk(32'(exp_q.size()), 0, "scoreboard drained");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter for the Sys0 peripheral subsystem. It accepts bytes from the bus-side register interface into a FIFO and serialises them onto the RsTx line. The line is consumed by the SoC pad and by the bench serial terminal. At HCLK = 100 MHz with prescale = 15, one bit lasts 160 ns, which matches the terminal decoder.

Parameters:
FIFO_DEPTH, 16, number of FIFO entries; power of two, minimum 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
HCLK  input  1  system clock; all state updates on the rising edge.
HRESETn  input  1  asynchronous, active-low reset.
en  input  1  transmit enable; level-sensitive.
prescale  input  16  bit period minus 1, in HCLK cycles.
wdata  input  8  byte to enqueue.
wr  input  1  enqueue strobe; sampled on each rising edge.
ovf_clr  input  1  clears the sticky overflow flag.
tx  output  1  serial line (RsTx); idle high.
busy  output  1  high while a frame is in flight (any state except IDLE).
full  output  1  FIFO holds FIFO_DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
ovf  output  1  sticky: a write was dropped because the FIFO was full.
tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, HRESETn low):
  - tx=1, busy=0, full=0, empty=1, level=0, ovf=0, tx_done=0.
  - FIFO pointers cleared; FSM goes to IDLE; baud counter cleared.
  - Reset mid-frame aborts the frame at once (tx=1); no partial byte is retried.
- FIFO:
  - Circular buffer with registered read/write pointers one bit wider than the address, for full/empty detection.
  - wr with full=0 stores wdata at edge k; level increments and empty drops after edge k.
  - wr with full=1 drops the byte and sets ovf at that edge, even if a pop occurs in the same cycle (full is evaluated from registered state).
  - A write and a pop in the same cycle with full=0 leave level unchanged; both operations take effect.
  - ovf_clr clears ovf. If ovf_clr and a dropped write coincide, set wins.
- Baud counter:
  - 16-bit down-counter, loaded with the prescale value latched at frame start (psc_q).
  - Bit tick when the counter reaches 0, after which it reloads psc_q.
  - Each bit lasts psc_q+1 cycles; prescale=0 gives 1 cycle per bit.
  - Changing prescale mid-frame has no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If en=1 and empty=0: pop the head entry into an 8-bit shift register, latch prescale into psc_q, load the counter, go to START.
    - Earliest start: wr at edge k, pop at edge k+1, tx=0 from edge k+1.
  - START: tx=0 for psc_q+1 cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[0], LSB first.
    - On each tick, shift right and increment the 3-bit index.
    - After the 8th bit, go to STOP.
  - STOP:
    - tx=1 for STOP_BITS*(psc_q+1) cycles.
    - On the final tick, pulse tx_done for one cycle and go to IDLE.
- Back-to-back frames: one IDLE cycle between frames, so the next start bit begins one cycle after the stop period ends.
  - Frame length is therefore (9+STOP_BITS)*(psc_q+1)+1 cycles when streaming.
- en:
  - Deasserting en mid-frame lets the current frame complete.
  - No new frame starts while en=0.
  - The FIFO continues to accept writes while en=0.
- busy=1 in START, DATA and STOP.
- tx is driven from a flop (glitch-free).

Test Plan:
1. Reset → check every output matches its reset value.
   - Then drive wr=1 with wdata=0x55, prescale=15, en=1.
   - Expect tx low at edge k+1.
   - Expect tx sequence 0,1,0,1,0,1,0,1,0,1 with each level held 16 cycles.
   - Expect tx_done one cycle after the stop bit; a terminal model with bit_time=160 ns prints 'U'.
2. en=0; write 17 bytes 0x00..0x10 → full=1 after the 16th write, 17th byte dropped, ovf=1, level=16.
   - Then set en=1 → bytes 0x00..0x0F are emitted in order.
   - Expect 16 tx_done pulses, then empty=1, busy=0.
   - Pulse ovf_clr → ovf=0.
3. Streaming with prescale=3, STOP_BITS=1: write 0xA3 then 0x0F.
   - Expect tx_done pulses exactly 41 cycles apart.
   - Expect decoded bytes 0xA3, 0x0F.
4. Deassert en during the DATA phase of byte 0x81 with 2 bytes queued.
   - Expect the current frame to complete, then tx stays 1 and level=1 remains.
   - Re-assert en → the queued byte is sent.
5. Assert HRESETn=0 during bit 4 of a frame → tx=1 within the same cycle (asynchronous), level=0, busy=0.
   - After release, no further tx activity without new writes.
6. With STOP_BITS=2 and prescale=0: write 0xFF.
   - Expect tx low for exactly 1 cycle, then high.
   - Expect tx_done 11 cycles after tx falls.
   - Change prescale to 7 mid-frame → frame timing is unchanged.
